key_vault: RTL

//  Parametrised multi-slot key store with password-gated release, failed-attempt lockout and license timeout.

---
 rtl/key_vault_pkg.sv | 25 ++
 rtl/key_vault_down_counter.sv | 39 +++
 rtl/key_vault.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/key_vault_pkg.sv
// Shared types and width helpers for the key vault.
package key_vault_pkg;

   typedef enum logic [1:0] {
      KV_IDLE = 2'd0,
      KV_LIC  = 2'd1,
      KV_LOCK = 2'd2
   } kv_state_e;

   // Slot index width: at least one bit even for a single-slot vault.
   function automatic int unsigned kv_slot_w(input int unsigned num_slots);
      int unsigned w;
      w = (num_slots <= 1) ? 1 : $clog2(num_slots);
      return w;
   endfunction

   // Shared timer width: must hold the larger of lockout and license lifetime.
   function automatic int unsigned kv_timer_w(input int unsigned lock_cycles,
                                              input int unsigned lic_timeout);
      int unsigned m;
      m = (lock_cycles > lic_timeout) ? lock_cycles : lic_timeout;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_vault_down_counter.sv
// Loadable down-counter used as the vault's shared license/lockout timer.
module kv_down_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] out,
   output logic         is_one
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Load wins over decrement; a zero count holds instead of wrapping.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign out    = count_q;
   assign is_one = (count_q == W'(1));

endmodule

// File: rtl/key_vault.sv
// Multi-slot key store releasing the selected key only while licensed,
// with failed-attempt lockout and optional license expiry.
module key_vault
   import key_vault_pkg::*;
#(
   parameter int unsigned      KEY_W       = 128,
   parameter int unsigned      NUM_SLOTS   = 4,
   parameter int unsigned      PW_W        = 8,
   parameter logic [PW_W-1:0]  PASSWORD    = 8'hAA,
   parameter logic [KEY_W-1:0] RESET_KEY   = 128'habcd,
   parameter int unsigned      MAX_FAILS   = 3,
   parameter int unsigned      LOCK_CYCLES = 256,
   parameter int unsigned      LIC_TIMEOUT = 1024,
   localparam int unsigned     SLOT_W      = kv_slot_w(NUM_SLOTS),
   localparam int unsigned     FCNT_W      = $clog2(MAX_FAILS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [SLOT_W-1:0] wr_slot,
   input  logic [KEY_W-1:0]  wr_key,
   input  logic              pw_valid,
   input  logic [PW_W-1:0]   password,
   input  logic [SLOT_W-1:0] rd_slot,
   output logic [KEY_W-1:0]  key_out,
   output logic              key_val,
   output logic              locked,
   output logic [FCNT_W-1:0] fail_cnt
);

   localparam int unsigned TMR_W = kv_timer_w(LOCK_CYCLES, LIC_TIMEOUT);

   kv_state_e         state_q, state_d;
   logic [FCNT_W-1:0] fail_q, fail_d;
   logic [KEY_W-1:0]  slot_q [NUM_SLOTS];
   logic [KEY_W-1:0]  rd_key;

   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_load_val;
   logic              tmr_dec;
   logic [TMR_W-1:0]  tmr_q;
   logic              tmr_one;
   logic              tmr_done;

   logic              wr_ok;
   logic              rd_ok;
   logic              pw_ok;
   logic              fail_hit;
   logic              lic;

   assign wr_ok    = wr_en && (32'(wr_slot) < NUM_SLOTS);
   assign rd_ok    = 32'(rd_slot) < NUM_SLOTS;
   assign pw_ok    = (password == PASSWORD);
   assign fail_hit = (32'(fail_q) + 32'd1) >= MAX_FAILS;
   // A zero count in a timed state is treated as expired so the FSM cannot stick.
   assign tmr_done = tmr_one || (tmr_q == '0);

   kv_down_counter #(
      .W (TMR_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .out      (tmr_q),
      .is_one   (tmr_one)
   );

   // State and failure-count registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= KV_IDLE;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         fail_q  <= fail_d;
      end
   end

   // Next state: a valid write preempts the password attempt, which preempts expiry.
   always_comb begin
      state_d      = state_q;
      fail_d       = fail_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_dec      = 1'b0;
      unique case (state_q)
         KV_IDLE: begin
            if (!wr_ok && pw_valid) begin
               if (pw_ok) begin
                  state_d      = KV_LIC;
                  fail_d       = '0;
                  tmr_load     = 1'b1;
                  tmr_load_val = TMR_W'(LIC_TIMEOUT);
               end else if (fail_hit) begin
                  state_d      = KV_LOCK;
                  fail_d       = FCNT_W'(MAX_FAILS);
                  tmr_load     = 1'b1;
                  tmr_load_val = TMR_W'(LOCK_CYCLES);
               end else begin
                  fail_d = fail_q + FCNT_W'(1);
               end
            end
         end
         KV_LIC: begin
            if (wr_ok) begin
               state_d = KV_IDLE;
            end else if (pw_valid) begin
               if (pw_ok) begin
                  tmr_load     = 1'b1;
                  tmr_load_val = TMR_W'(LIC_TIMEOUT);
               end else if (MAX_FAILS == 1) begin
                  state_d      = KV_LOCK;
                  fail_d       = FCNT_W'(1);
                  tmr_load     = 1'b1;
                  tmr_load_val = TMR_W'(LOCK_CYCLES);
               end else begin
                  state_d = KV_IDLE;
                  fail_d  = FCNT_W'(1);
               end
            end else if (LIC_TIMEOUT != 0) begin
               if (tmr_done) begin
                  state_d = KV_IDLE;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
         end
         KV_LOCK: begin
            // Lockout runs its full length regardless of writes or attempts.
            if (tmr_done) begin
               state_d = KV_IDLE;
               fail_d  = '0;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: begin
            state_d = KV_IDLE;
         end
      endcase
   end

   // Slot storage: every slot reloads the reset key; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slot_q[i] <= RESET_KEY;
         end
      end else if (wr_ok) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (wr_slot == SLOT_W'(i)) begin
               slot_q[i] <= wr_key;
            end
         end
      end
   end

   // Read mux over the populated slots only.
   always_comb begin
      rd_key = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
         if (rd_slot == SLOT_W'(i)) begin
            rd_key = slot_q[i];
         end
      end
   end

   assign lic      = (state_q == KV_LIC) && !reset;
   assign key_out  = (lic && rd_ok) ? rd_key : '0;
   assign key_val  = lic && !wr_en && rd_ok;
   assign locked   = (state_q == KV_LOCK) && !reset;
   assign fail_cnt = fail_q;

endmodule
